// File: rtl/value_lane_serializer.sv
// value_lane_serializer
//
// Transmit end of the narrow value link. One WIDTH-bit value is accepted per
// ready/valid handshake. It is then sent LSB-first as BEATS beats of LANE bits.
// o_out_last marks the final beat of each word.
//
// Optional feature, selected by the macro VALUE_LANE_SERIALIZER_PARITY_EN:
//   When the macro is defined, one extra beat follows the data beats.
//   o_out_data[0] of that beat is the even parity (XOR of all value bits).
//   The other bits of that beat are 0.
//   o_out_last is set only on this parity beat.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   upstream value valid
//   o_in_ready   upstream ready (combinational, allows back-to-back words)
//   i_in_value   value to transmit, sampled only on accept
//   o_out_valid  link beat valid (registered)
//   i_out_ready  link ready
//   o_out_data   beat payload (registered)
//   o_out_last   final beat of the word (registered)
//   o_busy       high while a word is held

module value_lane_serializer #(
  parameter int WIDTH = 10,
  parameter int LANE  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_value,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [LANE-1:0]  o_out_data,
  output logic             o_out_last,
  output logic             o_busy
);

  localparam int BEATS = (WIDTH + LANE - 1) / LANE;
  localparam int HW    = BEATS * LANE;
`ifdef VALUE_LANE_SERIALIZER_PARITY_EN
  localparam int TOTAL = BEATS + 1;
`else
  localparam int TOTAL = BEATS;
`endif
  localparam int CW = ($clog2(BEATS + 1) < 1) ? 1 : $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [HW-1:0]   r_hold;
  logic [CW-1:0]   r_cnt;
  logic            r_out_valid;
  logic [LANE-1:0] r_out_data;
  logic            r_out_last;
`ifdef VALUE_LANE_SERIALIZER_PARITY_EN
  logic            r_parity;
`endif

  logic            w_in_fire;
  logic            w_out_fire;
  logic [CW-1:0]   w_idx;
  logic [LANE-1:0] w_next_data;
  logic [HW-1:0]   w_in_padded;

  assign w_out_fire  = r_out_valid && i_out_ready;
  assign w_in_fire   = i_in_valid && o_in_ready;
  assign w_idx       = r_cnt + 1'b1;
  // Zero-pad the value up to a whole number of beats.
  // This makes the unused bits of the final data beat read as 0.
  assign w_in_padded = HW'(i_in_value);

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  // A word accepted on the same edge as the last beat keeps the FSM in SEND.
  // That removes any gap between words.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_in_fire) w_state_next = SEND;
      SEND: if (w_out_fire && r_out_last && !w_in_fire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic.
  // Ready is asserted while idle.
  // It is also asserted while the last beat is being taken, so the next word
  // can be loaded with no bubble.
  always_comb begin
    o_in_ready = (r_state == IDLE) || (w_out_fire && r_out_last);
    o_busy     = (r_state == SEND);
  end

  // Select the payload of the beat after the one currently presented.
  // Data beats come from the hold register.
  // In the parity build, the extra beat carries the stored parity bit.
  always_comb begin
    w_next_data = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (w_idx == CW'(k)) w_next_data = r_hold[k*LANE +: LANE];
    end
`ifdef VALUE_LANE_SERIALIZER_PARITY_EN
    if (w_idx == CW'(BEATS)) w_next_data = LANE'(r_parity);
`endif
  end

  // Beat datapath.
  // A new word loads the hold register and presents beat 0 on the next cycle.
  // A beat accept advances to the following beat, or drops valid after the last one.
  // With no accept, every output simply holds, which gives stable back-pressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
`ifdef VALUE_LANE_SERIALIZER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else if (w_in_fire) begin
      r_hold      <= w_in_padded;
      r_cnt       <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= w_in_padded[LANE-1:0];
      r_out_last  <= (LAST_IDX == '0);
`ifdef VALUE_LANE_SERIALIZER_PARITY_EN
      r_parity    <= ^i_in_value;
`endif
    end else if (w_out_fire) begin
      if (r_out_last) begin
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_last  <= 1'b0;
      end else begin
        r_cnt       <= w_idx;
        r_out_data  <= w_next_data;
        r_out_last  <= (w_idx == LAST_IDX);
      end
    end
  end

endmodule
